rr_grant_ctrl_4: RTL and testbench

Four-requester round-robin arbiter that shares a single resource, such as the 4x2 encoder datapath or a shared bus port, among up to four clients. Each winner receives a registered one-hot grant, the 2-bit encoded owner index, and a valid flag, which matches the in/out/valid convention of the encoder blocks. A grant is held until the owner releases it, drops its request, or exceeds a hold-time limit. Round-robin priority prevents starvation.

---
 rtl/rr_grant_ctrl_4.sv | 88 ++++++++
 tb/tb_rr_grant_ctrl_4.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl_4.sv
// Four-requester round-robin arbiter with a registered one-hot grant, encoded owner index,
// hold-time limit, and a mandatory idle cycle between successive owners.
module rr_grant_ctrl_4 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] owner;
    logic [7:0] hold_cnt;

    logic [1:0] pick_idx;
    logic       pick_valid;
    logic       release_now;

    // Scan from the farthest offset back toward ptr so the closest requester wins.
    always_comb begin
        pick_idx   = ptr;
        pick_valid = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                pick_idx   = ptr + 2'(i);
                pick_valid = 1'b1;
            end
        end
    end

    assign release_now = done || !req[owner] || (hold_cnt == HOLD_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            owner       <= 2'd0;
            hold_cnt    <= 8'd0;
            grant       <= 4'b0000;
            grant_idx   <= 2'd0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick_idx;
                        grant       <= 4'b0001 << pick_idx;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        hold_cnt    <= 8'd1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant       <= 4'b0000;
                        grant_idx   <= 2'd0;
                        grant_valid <= 1'b0;
                        hold_cnt    <= 8'd0;
                        ptr         <= owner + 2'd1;
                        state       <= IDLE;
                        // A limit release that coincides with done or a request drop is a normal release.
                        timeout     <= !done && req[owner];
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl_4.sv
// Directed self-checking bench for rr_grant_ctrl_4: one instance at the default hold
// limit and one at HOLD_MAX=4 for the timeout scenarios.
module tb_rr_grant_ctrl_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, req4;
    logic       done, done4;
    logic [3:0] grant, grant4;
    logic [1:0] grant_idx, grant_idx4;
    logic       grant_valid, grant_valid4;
    logic       timeout, timeout4;

    // Observed outputs packed as {grant, grant_idx, grant_valid, timeout}.
    logic [7:0] obs, obs4;
    assign obs  = {grant, grant_idx, grant_valid, timeout};
    assign obs4 = {grant4, grant_idx4, grant_valid4, timeout4};

    int checks   = 0;
    int failures = 0;

    rr_grant_ctrl_4 dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    rr_grant_ctrl_4 #(.HOLD_MAX(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .req        (req4),
        .done       (done4),
        .grant      (grant4),
        .grant_idx  (grant_idx4),
        .grant_valid(grant_valid4),
        .timeout    (timeout4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;
        req4  = 4'b0000;
        done4 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (obs !== 8'b0000_00_0_0) begin
                failures++;
                $display("[TB] FAIL reset_idle cycle %0d: got %b expected %b", c, obs, 8'b0000_00_0_0);
            end
        end
    endtask

    task automatic test_rr_skip();
        logic [7:0] exp_seq [7];
        logic       done_seq [7];
        exp_seq  = '{8'b0010_01_1_0, 8'b0010_01_1_0, 8'b0010_01_1_0, 8'b0000_00_0_0,
                     8'b1000_11_1_0, 8'b0000_00_0_0, 8'b0010_01_1_0};
        done_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        req = 4'b1010;
        for (int c = 0; c < 7; c++) begin
            tick();
            checks++;
            if (obs !== exp_seq[c]) begin
                failures++;
                $display("[TB] FAIL rr_skip step %0d: got %b expected %b", c, obs, exp_seq[c]);
            end
            done = done_seq[c];
        end
        done = 1'b0;
        req  = 4'b0000;
    endtask

    task automatic test_rotate();
        logic [7:0] exp_seq [9];
        exp_seq = '{8'b0001_00_1_0, 8'b0000_00_0_0, 8'b0010_01_1_0, 8'b0000_00_0_0,
                    8'b0100_10_1_0, 8'b0000_00_0_0, 8'b1000_11_1_0, 8'b0000_00_0_0,
                    8'b0001_00_1_0};
        do_reset();
        req  = 4'b1111;
        done = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick();
            checks++;
            if (obs !== exp_seq[c]) begin
                failures++;
                $display("[TB] FAIL rotate step %0d: got %b expected %b", c, obs, exp_seq[c]);
            end
        end
        done = 1'b0;
        req  = 4'b0000;
    endtask

    task automatic test_timeout();
        do_reset();
        req4 = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (obs4 !== 8'b0100_10_1_0) begin
                failures++;
                $display("[TB] FAIL timeout_hold cycle %0d: got %b expected %b", c, obs4, 8'b0100_10_1_0);
            end
        end
        tick();
        checks++;
        if (obs4 !== 8'b0000_00_0_1) begin
            failures++;
            $display("[TB] FAIL timeout_pulse: got %b expected %b", obs4, 8'b0000_00_0_1);
        end
        // Re-grant, then let done coincide with the limit: a normal release, no pulse.
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (obs4 !== 8'b0100_10_1_0) begin
                failures++;
                $display("[TB] FAIL timeout_regrant cycle %0d: got %b expected %b", c, obs4, 8'b0100_10_1_0);
            end
        end
        done4 = 1'b1;
        tick();
        checks++;
        if (obs4 !== 8'b0000_00_0_0) begin
            failures++;
            $display("[TB] FAIL timeout_coincide_done: got %b expected %b", obs4, 8'b0000_00_0_0);
        end
        done4 = 1'b0;
        req4  = 4'b0000;
    endtask

    task automatic test_hold_default();
        int   held     = 0;
        logic released = 1'b0;
        logic to_seen  = 1'b0;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 40 && !released; c++) begin
            tick();
            if (grant === 4'b0001) begin
                held++;
            end else if (held > 0) begin
                released = 1'b1;
                to_seen  = timeout;
            end
        end
        checks++;
        if (released !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold16_release: got %b expected %b (no release within 40 cycles)", released, 1'b1);
        end
        checks++;
        if (held != 16) begin
            failures++;
            $display("[TB] FAIL hold16_length: got %0d expected %0d", held, 16);
        end
        checks++;
        if (to_seen !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold16_timeout: got %b expected %b", to_seen, 1'b1);
        end
        req = 4'b0000;
    endtask

    task automatic test_req_drop();
        logic [7:0] exp_seq [4];
        logic [3:0] req_seq [4];
        exp_seq = '{8'b0001_00_1_0, 8'b0001_00_1_0, 8'b0000_00_0_0, 8'b0010_01_1_0};
        req_seq = '{4'b0111, 4'b0110, 4'b0110, 4'b0110};
        do_reset();
        req = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (obs !== exp_seq[c]) begin
                failures++;
                $display("[TB] FAIL req_drop step %0d: got %b expected %b", c, obs, exp_seq[c]);
            end
            req = req_seq[c];
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        // Short grant to client 1 leaves ptr at 2, so a stale ptr would favour client 3 later.
        req  = 4'b0010;
        done = 1'b1;
        tick();
        req  = 4'b1000;
        done = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (obs !== 8'b1000_11_1_0) begin
            failures++;
            $display("[TB] FAIL midgrant_owner: got %b expected %b", obs, 8'b1000_11_1_0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 8'b0000_00_0_0) begin
            failures++;
            $display("[TB] FAIL midgrant_async_reset: got %b expected %b", obs, 8'b0000_00_0_0);
        end
        req = 4'b1001;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 8'b0001_00_1_0) begin
            failures++;
            $display("[TB] FAIL midgrant_ptr_reset: got %b expected %b", obs, 8'b0001_00_1_0);
        end
        req = 4'b0000;
    endtask

    initial begin
        $display("[TB] starting rr_grant_ctrl_4 directed tests");
        test_reset();
        test_rr_skip();
        test_rotate();
        test_timeout();
        test_hold_default();
        test_req_drop();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
